// File: rtl/pcb_test_pkg.sv
// Shared definitions for the PCB test top level: SPI state encoding,
// default converter frame geometry and a counter-width helper.
package pcb_test_pkg;

  // Default DAC/ADC serial frame geometry
  localparam int DAC_DATA_W  = 16;
  localparam int DAC_CLK_DIV = 4;
  localparam int DAC_CS_GAP  = 8;

  // State encoding shared by the serial engines
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_GAP   = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    SETUP = ST_SETUP,
    SHIFT = ST_SHIFT,
    GAP   = ST_GAP
  } spi_state_t;

  // Width of a counter that must hold 0..n-1; never narrower than one bit
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/spi_clk_en.sv
// Clock-enable divider: emits a one-cycle half_tick every CLK_DIV cycles
// while enabled, so serial clocks are generated without a derived clock.
module spi_clk_en
  import pcb_test_pkg::*;
#(
  parameter int CLK_DIV = DAC_CLK_DIV
) (
  input  logic clk,
  input  logic sys_rst,
  input  logic en,
  output logic half_tick
);

  localparam int CW = cnt_width(CLK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  // Free-running divide counter, held at zero while disabled so every
  // enable starts a full CLK_DIV period
  always_ff @(posedge clk) begin
    if (sys_rst || !en) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign half_tick = en && (cnt == CNT_LAST);

endmodule

// File: rtl/dac_spi_tx.sv
// Serial write master for the board DAC: takes a code over valid/ready and
// shifts it MSB-first on cs_n/sclk/din, all timed from clock enables on clk.
module dac_spi_tx
  import pcb_test_pkg::*;
#(
  parameter int DATA_W  = DAC_DATA_W,
  parameter int CLK_DIV = DAC_CLK_DIV,
  parameter int CS_GAP  = DAC_CS_GAP
) (
  input  logic              clk,
  input  logic              sys_rst,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              dac_cs_n,
  output logic              dac_sclk,
  output logic              dac_din,
  output logic              busy,
  output logic              done
);

  localparam int BW = cnt_width(DATA_W);
  localparam int GW = cnt_width(CS_GAP);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(CS_GAP - 1);

  spi_state_t state, state_d;

  logic [DATA_W-1:0] sr, sr_d;
  logic [BW-1:0]     bit_cnt, bit_cnt_d;
  logic [GW-1:0]     gap_cnt, gap_cnt_d;
  logic              last_low, last_low_d;
  logic              cs_n_q, cs_n_d;
  logic              sclk_q, sclk_d;
  logic              done_q, done_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              div_en;
  logic              half_tick;

  // The divider only runs while a frame is on the wire
  assign div_en = (state == SETUP) || (state == SHIFT);

  spi_clk_en #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_en (
    .clk       (clk),
    .sys_rst   (sys_rst),
    .en        (div_en),
    .half_tick (half_tick)
  );

  // Next-state and next-output decode; outputs are registered below so
  // nothing on the DAC pins is combinational from the inputs
  always_comb begin
    state_d    = state;
    sr_d       = sr;
    bit_cnt_d  = bit_cnt;
    gap_cnt_d  = gap_cnt;
    last_low_d = last_low;
    cs_n_d     = cs_n_q;
    sclk_d     = sclk_q;
    done_d     = 1'b0;

    unique case (state)
      IDLE: begin
        if (wr_valid && ready_q) begin
          state_d    = SETUP;
          sr_d       = wr_data;
          bit_cnt_d  = BIT_LAST;
          last_low_d = 1'b0;
          cs_n_d     = 1'b0;
          sclk_d     = 1'b0;
        end
      end

      SETUP: begin
        if (half_tick) begin
          state_d = SHIFT;
          sclk_d  = 1'b1;
        end
      end

      SHIFT: begin
        if (half_tick) begin
          if (sclk_q) begin
            // Falling edge: advance to the next bit unless bit 0 is out,
            // in which case bit 0 is held for one more low phase
            sclk_d = 1'b0;
            if (bit_cnt == '0) begin
              last_low_d = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt - BW'(1);
              sr_d      = {sr[DATA_W-2:0], 1'b0};
            end
          end else if (last_low) begin
            state_d   = GAP;
            gap_cnt_d = '0;
            sr_d      = '0;
            cs_n_d    = 1'b1;
            done_d    = 1'b1;
          end else begin
            sclk_d = 1'b1;
          end
        end
      end

      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt + GW'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  // State, datapath and output registers; reset aborts any frame in flight
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state    <= IDLE;
      sr       <= '0;
      bit_cnt  <= '0;
      gap_cnt  <= '0;
      last_low <= 1'b0;
      cs_n_q   <= 1'b1;
      sclk_q   <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state    <= state_d;
      sr       <= sr_d;
      bit_cnt  <= bit_cnt_d;
      gap_cnt  <= gap_cnt_d;
      last_low <= last_low_d;
      cs_n_q   <= cs_n_d;
      sclk_q   <= sclk_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
    end
  end

  assign wr_ready = ready_q;
  assign dac_cs_n = cs_n_q;
  assign dac_sclk = sclk_q;
  assign dac_din  = sr[DATA_W-1];
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_dac_spi_tx.sv
// Directed self-checking bench for dac_spi_tx: a default instance and a
// small-parameter instance, each watched by a deserialising monitor.
module tb_dac_spi_tx;

  logic        clk = 1'b0;
  logic        sys_rst;

  logic        wr_valid_a;
  logic [15:0] wr_data_a;
  logic        wr_ready_a, cs_n_a, sclk_a, din_a, busy_a, done_a;

  logic        wr_valid_b;
  logic [11:0] wr_data_b;
  logic        wr_ready_b, cs_n_b, sclk_b, din_b, busy_b, done_b;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  dac_spi_tx u_dut_a (
    .clk      (clk),
    .sys_rst  (sys_rst),
    .wr_valid (wr_valid_a),
    .wr_data  (wr_data_a),
    .wr_ready (wr_ready_a),
    .dac_cs_n (cs_n_a),
    .dac_sclk (sclk_a),
    .dac_din  (din_a),
    .busy     (busy_a),
    .done     (done_a)
  );

  dac_spi_tx #(
    .DATA_W  (12),
    .CLK_DIV (2),
    .CS_GAP  (1)
  ) u_dut_b (
    .clk      (clk),
    .sys_rst  (sys_rst),
    .wr_valid (wr_valid_b),
    .wr_data  (wr_data_b),
    .wr_ready (wr_ready_b),
    .dac_cs_n (cs_n_b),
    .dac_sclk (sclk_b),
    .dac_din  (din_b),
    .busy     (busy_b),
    .done     (done_b)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor state for instance A (offsets count the first cs_n-low cycle as 1)
  logic        prev_cs_a = 1'b1, prev_sclk_a = 1'b0, prev_ready_a = 1'b1;
  logic [15:0] cap_a = '0;
  logic [15:0] words_a [0:15];
  int rises_a = 0, total_rises_a = 0, last_rises_a = 0, frames_a = 0;
  int low_run_a = 0, high_run_a = 0, last_low_a = 0, last_high_a = 0;
  int accepts_a = 0, acc_cyc_a = 0, rise0_off_a = 0, done_off_a = 0;
  int ready_off_a = 0, done_cnt_a = 0;

  // Deserialise instance A on sclk rises and time its frame boundaries
  always @(negedge clk) begin
    if (cs_n_a === 1'b0) begin
      if (prev_cs_a === 1'b1) begin
        last_high_a = high_run_a;
        low_run_a   = 0;
        rises_a     = 0;
        cap_a       = '0;
      end
      low_run_a++;
    end else if (cs_n_a === 1'b1) begin
      if (prev_cs_a === 1'b0) begin
        last_low_a   = low_run_a;
        last_rises_a = rises_a;
        if (frames_a < 16) words_a[frames_a] = cap_a;
        frames_a++;
        high_run_a = 0;
      end
      high_run_a++;
    end
    if (sclk_a === 1'b1 && prev_sclk_a === 1'b0) begin
      if (rises_a == 0) rise0_off_a = cyc - acc_cyc_a + 1;
      rises_a++;
      total_rises_a++;
      cap_a = {cap_a[14:0], din_a};
    end
    if (done_a === 1'b1) begin
      done_cnt_a++;
      done_off_a = cyc - acc_cyc_a + 1;
    end
    if (wr_ready_a === 1'b1 && prev_ready_a === 1'b0) ready_off_a = cyc - acc_cyc_a + 1;
    if (sys_rst === 1'b0 && wr_valid_a === 1'b1 && wr_ready_a === 1'b1) begin
      accepts_a++;
      acc_cyc_a = cyc + 1;
    end
    prev_cs_a    = cs_n_a;
    prev_sclk_a  = sclk_a;
    prev_ready_a = wr_ready_a;
  end

  // Monitor state for instance B
  logic        prev_cs_b = 1'b1, prev_sclk_b = 1'b0, prev_ready_b = 1'b1;
  logic [11:0] cap_b = '0, word_b = '0;
  int rises_b = 0, last_rises_b = 0, frames_b = 0, low_run_b = 0, last_low_b = 0;
  int accepts_b = 0, acc_cyc_b = 0, done_off_b = 0, ready_off_b = 0;

  // Deserialise instance B on sclk rises and time its frame boundaries
  always @(negedge clk) begin
    if (cs_n_b === 1'b0) begin
      if (prev_cs_b === 1'b1) begin
        low_run_b = 0;
        rises_b   = 0;
        cap_b     = '0;
      end
      low_run_b++;
    end else if (cs_n_b === 1'b1 && prev_cs_b === 1'b0) begin
      last_low_b   = low_run_b;
      last_rises_b = rises_b;
      word_b       = cap_b;
      frames_b++;
    end
    if (sclk_b === 1'b1 && prev_sclk_b === 1'b0) begin
      rises_b++;
      cap_b = {cap_b[10:0], din_b};
    end
    if (done_b === 1'b1) done_off_b = cyc - acc_cyc_b + 1;
    if (wr_ready_b === 1'b1 && prev_ready_b === 1'b0) ready_off_b = cyc - acc_cyc_b + 1;
    if (sys_rst === 1'b0 && wr_valid_b === 1'b1 && wr_ready_b === 1'b1) begin
      accepts_b++;
      acc_cyc_b = cyc + 1;
    end
    prev_cs_b    = cs_n_b;
    prev_sclk_b  = sclk_b;
    prev_ready_b = wr_ready_b;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [15:0] data);
    wr_valid_a = valid;
    wr_data_a  = data;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n0, f0, f1, first_acc, snap_done, snap_rises;

    sys_rst    = 1'b1;
    wr_valid_b = 1'b0;
    wr_data_b  = '0;
    applyStimulus(1'b0, 16'h0000);
    repeat (3) tick();

    checkOutput("rst_cs_n", 32'(cs_n_a), 32'd1);
    checkOutput("rst_sclk", 32'(sclk_a), 32'd0);
    checkOutput("rst_din", 32'(din_a), 32'd0);
    checkOutput("rst_ready", 32'(wr_ready_a), 32'd1);
    checkOutput("rst_busy", 32'(busy_a), 32'd0);
    checkOutput("rst_done", 32'(done_a), 32'd0);

    sys_rst = 1'b0;
    repeat (2) tick();

    // Single frame 0xA5C3 at default parameters
    $display("[TB] single frame 0xA5C3");
    n0 = accepts_a;
    f0 = frames_a;
    applyStimulus(1'b1, 16'hA5C3);
    for (int i = 0; i < 10 && accepts_a == n0; i++) tick();
    checkOutput("single_accept", 32'(accepts_a), 32'(n0 + 1));
    applyStimulus(1'b0, 16'h0000);
    checkOutput("single_cs_fall", 32'(cs_n_a), 32'd0);
    checkOutput("single_din_msb", 32'(din_a), 32'd1);
    for (int i = 0; i < 300 && frames_a == f0; i++) tick();
    repeat (12) tick();
    checkOutput("single_frames", 32'(frames_a), 32'(f0 + 1));
    checkOutput("single_word", 32'(words_a[f0]), 32'h0000A5C3);
    checkOutput("single_rises", 32'(last_rises_a), 32'd16);
    checkOutput("single_cs_low", 32'(last_low_a), 32'd132);
    checkOutput("single_rise0", 32'(rise0_off_a), 32'd5);
    checkOutput("single_done_at", 32'(done_off_a), 32'd133);
    checkOutput("single_ready_at", 32'(ready_off_a), 32'd141);

    // Back-to-back extreme codes with wr_valid held
    $display("[TB] back-to-back 0x0000 / 0xFFFF");
    n0 = accepts_a;
    f0 = frames_a;
    applyStimulus(1'b1, 16'h0000);
    for (int i = 0; i < 10 && accepts_a == n0; i++) tick();
    checkOutput("b2b_accept0", 32'(accepts_a), 32'(n0 + 1));
    first_acc = acc_cyc_a;
    applyStimulus(1'b1, 16'hFFFF);
    for (int i = 0; i < 300 && accepts_a == n0 + 1; i++) tick();
    checkOutput("b2b_accept1", 32'(accepts_a), 32'(n0 + 2));
    applyStimulus(1'b0, 16'h0000);
    checkOutput("b2b_accept_gap", 32'(acc_cyc_a - first_acc), 32'd141);
    for (int i = 0; i < 400 && frames_a < f0 + 2; i++) tick();
    repeat (12) tick();
    checkOutput("b2b_word0", 32'(words_a[f0]), 32'h00000000);
    checkOutput("b2b_word1", 32'(words_a[f0 + 1]), 32'h0000FFFF);
    checkOutput("b2b_cs_high", 32'(last_high_a), 32'd9);
    checkOutput("b2b_rises1", 32'(last_rises_a), 32'd16);

    // Data stability with wr_data scrambled and wr_valid held while busy
    $display("[TB] data stability 0x1234");
    n0 = accepts_a;
    f0 = frames_a;
    applyStimulus(1'b1, 16'h1234);
    for (int i = 0; i < 10 && accepts_a == n0; i++) tick();
    for (int i = 0; i < 60; i++) begin
      applyStimulus(1'b1, 16'($urandom));
      tick();
    end
    checkOutput("stab_busy", 32'(busy_a), 32'd1);
    checkOutput("stab_no_accept", 32'(accepts_a), 32'(n0 + 1));
    applyStimulus(1'b0, 16'h0000);
    for (int i = 0; i < 300 && frames_a == f0; i++) tick();
    repeat (12) tick();
    checkOutput("stab_word", 32'(words_a[f0]), 32'h00001234);

    // Reset after the 7th rise of a 0x8001 frame
    $display("[TB] reset mid-frame 0x8001");
    n0 = accepts_a;
    applyStimulus(1'b1, 16'h8001);
    for (int i = 0; i < 10 && accepts_a == n0; i++) tick();
    applyStimulus(1'b0, 16'h0000);
    for (int i = 0; i < 200 && rises_a != 7; i++) tick();
    checkOutput("mid_reach_rise7", 32'(rises_a), 32'd7);
    snap_done  = done_cnt_a;
    snap_rises = total_rises_a;
    sys_rst = 1'b1;
    tick();
    checkOutput("mid_cs_high", 32'(cs_n_a), 32'd1);
    checkOutput("mid_sclk_low", 32'(sclk_a), 32'd0);
    sys_rst = 1'b0;
    repeat (40) tick();
    checkOutput("mid_no_done", 32'(done_cnt_a), 32'(snap_done));
    checkOutput("mid_no_sclk", 32'(total_rises_a), 32'(snap_rises));
    checkOutput("mid_ready", 32'(wr_ready_a), 32'd1);
    n0 = accepts_a;
    f1 = frames_a;
    applyStimulus(1'b1, 16'h0F0F);
    for (int i = 0; i < 10 && accepts_a == n0; i++) tick();
    applyStimulus(1'b0, 16'h0000);
    for (int i = 0; i < 300 && frames_a == f1; i++) tick();
    repeat (12) tick();
    checkOutput("mid_next_word", 32'(words_a[f1]), 32'h00000F0F);
    checkOutput("mid_next_rises", 32'(last_rises_a), 32'd16);

    // Small-parameter instance: DATA_W=12, CLK_DIV=2, CS_GAP=1
    $display("[TB] parameter sweep 0xABC");
    n0 = accepts_b;
    f0 = frames_b;
    wr_valid_b = 1'b1;
    wr_data_b  = 12'hABC;
    for (int i = 0; i < 10 && accepts_b == n0; i++) tick();
    wr_valid_b = 1'b0;
    wr_data_b  = 12'h000;
    for (int i = 0; i < 200 && frames_b == f0; i++) tick();
    repeat (6) tick();
    checkOutput("sweep_frames", 32'(frames_b), 32'(f0 + 1));
    checkOutput("sweep_word", 32'(word_b), 32'h00000ABC);
    checkOutput("sweep_rises", 32'(last_rises_b), 32'd12);
    checkOutput("sweep_cs_low", 32'(last_low_b), 32'd50);
    checkOutput("sweep_done_at", 32'(done_off_b), 32'd51);
    checkOutput("sweep_ready_at", 32'(ready_off_b), 32'd52);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dac_spi_tx.md
# dac_spi_tx

Serial write master for the board's SPI-style DAC: accepts a 16-bit code over a valid/ready handshake and shifts it out MSB-first on a chip-select/serial-clock/data-out interface. It is the write-direction counterpart of the ADC read path. It sits beside the ADC reader in the PCB test top level, where it drives test voltages back onto the board. It is built with a clock-enable divider, not a derived clock, so everything stays on `clk`.

## Interface
- `DATA_W`, 16: frame length in bits, shifted MSB-first.
- `CLK_DIV`, 4: `clk` cycles per `dac_sclk` half-period. Must be ≥ 2.
- `CS_GAP`, 8: minimum `clk` cycles with `dac_cs_n` high between frames.
- `clk`  in  1  system clock (50 MHz).
- `sys_rst`  in  1  synchronous, active-high reset.
- `wr_valid`  in  1  write request.
- `wr_data`  in  DATA_W  DAC code; sampled only on an accepted cycle.
- `wr_ready`  out  1  block can accept a frame.
- `dac_cs_n`  out  1  DAC chip select, active low.
- `dac_sclk`  out  1  serial clock; idles low.
- `dac_din`  out  1  serial data; DAC samples it on the `dac_sclk` rising edge.
- `busy`  out  1  high from accept until the end of the gap.
- `done`  out  1  one-cycle pulse when `dac_cs_n` returns high.

## Operation
- States are IDLE → SETUP → SHIFT → GAP → IDLE.
- **IDLE**
  - `wr_ready`=1.
  - When `wr_valid`&&`wr_ready`, latch `wr_data` into the shift register, load bit counter = DATA_W−1, and go to SETUP.
  - Later changes on `wr_data` have no effect on the frame in flight.
- **SETUP**
  - Lasts CLK_DIV cycles.
  - `dac_cs_n`=0, `dac_sclk`=0, `dac_din`=MSB.
- **SHIFT**
  - Each bit = CLK_DIV cycles with `dac_sclk`=1, then CLK_DIV cycles with `dac_sclk`=0.
  - On the falling edge, `dac_din` advances to the next bit and the bit counter decrements.
  - After the low phase of bit 0, go to GAP. `dac_din` holds bit 0 through that low phase.
- **GAP**
  - `dac_cs_n`=1, `dac_sclk`=0, `dac_din`=0.
  - `done`=1 on the first GAP cycle only.
  - Lasts CS_GAP cycles, then IDLE.
- `wr_ready`=0 in SETUP, SHIFT and GAP. `busy` = not IDLE.
- A request held through a busy frame is accepted in the first IDLE cycle. Back-to-back frames are therefore separated by exactly CS_GAP+1 cycles of `dac_cs_n` high.
- **Reset** (dominates everything):
  - State IDLE, `dac_cs_n`=1, `dac_sclk`=0, `dac_din`=0, `done`=0, `busy`=0, `wr_ready`=1.
  - Reset mid-frame aborts the frame with no `done` pulse; `dac_cs_n` is high on the cycle after reset is sampled.
  - Reset and `wr_valid` in the same cycle: the request is not accepted.

## Timing
- All outputs are registered; none is combinational from inputs.
- Accept at edge N:
  - `dac_cs_n` falls and `dac_din`=MSB at N+1.
  - First `dac_sclk` rise at N+1+CLK_DIV.
  - Rise k (0-based) at N+1+CLK_DIV·(1+2k).
- `dac_cs_n` low for CLK_DIV·(1+2·DATA_W) cycles: 132 at defaults. `done` is at N+133.
- `wr_ready` returns at N+1+132+CS_GAP = N+141 at defaults.
- Exactly DATA_W rising edges per frame. `dac_din` is stable for ≥ CLK_DIV cycles on both sides of each rising edge.
- Divider counter width is clog2(CLK_DIV); it wraps to 0 at CLK_DIV−1 with no extra cycle.
- Bit counter width is clog2(DATA_W). The terminal count is at 0 and never underflows.

## Structure
- Shared package `pcb_test_pkg` holds:
  - the state encoding (IDLE/SETUP/SHIFT/GAP localparams);
  - the default DAC frame width and CLK_DIV, which the ADC reader also uses.
- Sub-module `spi_clk_en`: counter producing one-cycle `half_tick` strobes every CLK_DIV cycles while enabled. It is cleared by `sys_rst` or when disabled, and is reusable by the ADC path.
- The top-level FSM, shift register, bit counter and output registers live in `dac_spi_tx`.

## Test plan
- **Reset values:** hold `sys_rst` 3 cycles → `dac_cs_n`=1, `dac_sclk`=0, `dac_din`=0, `wr_ready`=1, `busy`=0, `done`=0.
- **Single frame:** write 0xA5C3 at defaults.
  - Monitor deserialises on `dac_sclk` rising edges: 0xA5C3, 16 rises.
  - `dac_cs_n` low 132 cycles; `done` at accept+133; `wr_ready` at accept+141.
- **Extreme codes:** frames 0x0000 then 0xFFFF with `wr_valid` held continuously.
  - Second accept on the first IDLE cycle; `dac_cs_n` high exactly 9 cycles between frames.
  - Both words captured correctly.
- **Data stability:** change `wr_data` every cycle after accepting 0x1234 → captured word is 0x1234. `wr_valid` while busy is not accepted.
- **Reset mid-frame:** assert `sys_rst` after the 7th rise of a 0x8001 frame.
  - `dac_cs_n`=1 next cycle, no `done`, no further `dac_sclk` edges.
  - A subsequent 0x0F0F frame is captured intact.
- **Parameter sweep:** CLK_DIV=2, CS_GAP=1, DATA_W=12, write 0xABC → 12 rises, `dac_cs_n` low 50 cycles, captured 0xABC.
